// File: rtl/mult_pkg.sv
// Shared types and default widths for the Booth multiplier sequencer.
// Holds the FSM state enum and the default width/timeout parameters.
package mult_pkg;

  localparam int ANCHO_OP_DEF  = 3;
  localparam int ANCHO_RES_DEF = 2 * ANCHO_OP_DEF;
  localparam int TIMEOUT_DEF   = 16;

  typedef enum logic [2:0] {
    REPOSO,
    ARRANQUE,
    ESPERA_BAJA,
    ESPERA_FIN,
    ENTREGA
  } estado_t;

endpackage

// File: rtl/secuenciador_mult_temporizador_espera.sv
// Wait-cycle timer for the multiplier sequencer.
// Ports: clk, rst_n, limpiar_i (clear), habilitar_i (count), vencido_o (terminal).
module temporizador_espera
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpiar_i,
  input  logic habilitar_i,
  output logic vencido_o
);

  localparam int AW = $clog2(TIMEOUT_CICLOS + 1);

  logic [AW-1:0] cuenta_q;
  logic [AW-1:0] cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (limpiar_i) begin
      cuenta_d = '0;
    end else if (habilitar_i) begin
      cuenta_d = cuenta_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  // Flags the enabled cycle whose increment brings the count to the limit,
  // so the FSM leaves on exactly the TIMEOUT_CICLOS-th wait cycle.
  assign vencido_o = habilitar_i &&
                     (cuenta_q == AW'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/secuenciador_mult.sv
// Valid/ready front/back end around the Booth multiplier: latch, start, wait, deliver.
// Ports: ent_* input channel, mult_* multiplier side, sal_* output channel, ocupado, num_ops.
module secuenciador_mult
  import mult_pkg::*;
#(
  parameter int ANCHO_OP       = ANCHO_OP_DEF,
  parameter int ANCHO_RES      = 2 * ANCHO_OP,
  parameter int TIMEOUT_CICLOS = TIMEOUT_DEF,
  parameter int ANCHO_CNT      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ent_valido,
  output logic                 ent_listo,
  input  logic [ANCHO_OP-1:0]  ent_multiplicador,
  input  logic [ANCHO_OP-1:0]  ent_multiplicando,
  output logic [ANCHO_OP-1:0]  mult_multiplicador,
  output logic [ANCHO_OP-1:0]  mult_multiplicando,
  output logic                 mult_start,
  input  logic                 mult_fin,
  input  logic [ANCHO_RES-1:0] mult_resultado,
  output logic                 sal_valido,
  input  logic                 sal_listo,
  output logic [ANCHO_RES-1:0] sal_resultado,
  output logic                 sal_error,
  output logic                 ocupado,
  output logic [ANCHO_CNT-1:0] num_ops
);

  estado_t              estado_q;
  logic                 listo_q;
  logic                 start_q;
  logic                 valido_q;
  logic                 error_q;
  logic                 ocupado_q;
  logic [ANCHO_OP-1:0]  mr_q;
  logic [ANCHO_OP-1:0]  md_q;
  logic [ANCHO_RES-1:0] res_q;
  logic [ANCHO_CNT-1:0] ops_q;

  logic limpiar;
  logic espera;
  logic vencido;

  assign limpiar = (estado_q == ARRANQUE);
  assign espera  = (estado_q == ESPERA_BAJA) ||
                   (estado_q == ESPERA_FIN);

  temporizador_espera #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_temporizador (
    .clk        (clk),
    .rst_n      (rst_n),
    .limpiar_i  (limpiar),
    .habilitar_i(espera),
    .vencido_o  (vencido)
  );

  // listo_q keeps the input channel closed until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      listo_q   <= 1'b0;
      start_q   <= 1'b0;
      valido_q  <= 1'b0;
      error_q   <= 1'b0;
      ocupado_q <= 1'b0;
      mr_q      <= '0;
      md_q      <= '0;
      res_q     <= '0;
      ops_q     <= '0;
    end else begin
      listo_q <= 1'b1;
      start_q <= 1'b0;
      unique case (estado_q)
        REPOSO: begin
          if (ent_valido && listo_q) begin
            mr_q      <= ent_multiplicador;
            md_q      <= ent_multiplicando;
            start_q   <= 1'b1;
            ocupado_q <= 1'b1;
            estado_q  <= ARRANQUE;
          end
        end
        ARRANQUE: begin
          estado_q <= ESPERA_BAJA;
        end
        ESPERA_BAJA: begin
          if (vencido) begin
            res_q    <= '0;
            error_q  <= 1'b1;
            valido_q <= 1'b1;
            estado_q <= ENTREGA;
          end else if (!mult_fin) begin
            estado_q <= ESPERA_FIN;
          end
        end
        ESPERA_FIN: begin
          // fin is checked first so it wins over a coincident timeout
          if (mult_fin) begin
            res_q    <= mult_resultado;
            error_q  <= 1'b0;
            valido_q <= 1'b1;
            estado_q <= ENTREGA;
          end else if (vencido) begin
            res_q    <= '0;
            error_q  <= 1'b1;
            valido_q <= 1'b1;
            estado_q <= ENTREGA;
          end
        end
        ENTREGA: begin
          if (sal_listo) begin
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            ops_q     <= ops_q + 1'b1;
            estado_q  <= REPOSO;
          end
        end
        default: begin
          estado_q <= REPOSO;
        end
      endcase
    end
  end

  assign ent_listo          = (estado_q == REPOSO) && listo_q;
  assign mult_multiplicador = mr_q;
  assign mult_multiplicando = md_q;
  assign mult_start         = start_q;
  assign sal_valido         = valido_q;
  assign sal_resultado      = res_q;
  assign sal_error          = error_q;
  assign ocupado            = ocupado_q;
  assign num_ops            = ops_q;

endmodule

// File: doc/secuenciador_mult.md
Name: secuenciador_mult

Overview:
Handshake front/back end for the 3-bit Booth multiplier.
- Accepts operand pairs on a valid/ready input channel and latches them.
- Drives the multiplier's operand inputs and issues a one-cycle start pulse.
- Waits for a fresh fin, captures the 6-bit product and presents it on a valid/ready output channel.
- Adds a timeout guard and an operation counter.
- Sits directly around the multiplier top: upstream of its start/operand inputs, downstream of its resultado/fin outputs.

Parameters:
ANCHO_OP, 3, operand width (two's complement)
ANCHO_RES, 2*ANCHO_OP, product width
TIMEOUT_CICLOS, 16, maximum wait cycles for fin before error
ANCHO_CNT, 8, width of completed-operation counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ent_valido  in  1  operand pair valid
ent_listo  out  1  sequencer can accept operands
ent_multiplicador  in  ANCHO_OP  multiplier operand
ent_multiplicando  in  ANCHO_OP  multiplicand operand
mult_multiplicador  out  ANCHO_OP  latched operand to multiplier
mult_multiplicando  out  ANCHO_OP  latched operand to multiplier
mult_start  out  1  start pulse to multiplier
mult_fin  in  1  multiplier done level
mult_resultado  in  ANCHO_RES  multiplier product
sal_valido  out  1  result valid
sal_listo  in  1  consumer ready
sal_resultado  out  ANCHO_RES  captured product (signed)
sal_error  out  1  result produced by timeout
ocupado  out  1  operation in flight (state != REPOSO)
num_ops  out  ANCHO_CNT  completed-handshake counter

Behaviour:
- Reset (rst_n low, asynchronous):
  - State REPOSO.
  - mult_start, sal_valido, sal_error, ocupado = 0.
  - sal_resultado, num_ops, latched operands, timeout counter = 0.
  - ent_listo = 1 from the first clk edge after release.
- FSM states: REPOSO, ARRANQUE, ESPERA_BAJA, ESPERA_FIN, ENTREGA.
- REPOSO:
  - ent_listo = 1.
  - On ent_valido: latch both operands, go to ARRANQUE.
- ARRANQUE:
  - mult_start = 1 for exactly one cycle.
  - Clear timeout counter.
  - Go to ESPERA_BAJA.
- ESPERA_BAJA:
  - Wait for mult_fin == 0, which rejects a stale fin left over from the previous operation, then go to ESPERA_FIN.
- ESPERA_FIN:
  - On mult_fin == 1: sal_resultado <= mult_resultado, sal_error <= 0, go to ENTREGA.
- Timeout:
  - Counter increments every cycle in ESPERA_BAJA and ESPERA_FIN.
  - On reaching TIMEOUT_CICLOS: sal_resultado <= 0, sal_error <= 1, go to ENTREGA.
  - If fin and timeout coincide, fin wins (sal_error = 0).
- ENTREGA:
  - sal_valido = 1.
  - sal_resultado and sal_error are held stable until sal_listo.
  - On handshake: num_ops increments (wraps 2^ANCHO_CNT-1 -> 0; error results counted too), go to REPOSO.
  - No same-cycle acceptance of new operands.
- Operand stability:
  - mult_multiplicador and mult_multiplicando are held constant from ARRANQUE until the next REPOSO acceptance.
  - The multiplier samples on the falling edge, so operands must be stable across the start cycle.
- Busy handling: ent_listo = 0 outside REPOSO; ent_valido there is ignored and nothing is latched.
- Registering and latency:
  - All outputs are registered except ent_listo, which is decoded from state.
  - Minimum latency from ent handshake to sal_valido = 3 cycles plus multiplier time.
- Arithmetic: operands pass unchanged; the product is a two's-complement ANCHO_RES value.
- Reset mid-operation:
  - Immediate return to REPOSO; mult_start drops asynchronously; any partial result is discarded.
  - The next ARRANQUE reloads the multiplier, so no recovery cycle is needed.

Decomposition:
- Package mult_pkg holds:
  - state enum estado_t (REPOSO, ARRANQUE, ESPERA_BAJA, ESPERA_FIN, ENTREGA);
  - default widths ANCHO_OP / ANCHO_RES;
  - TIMEOUT_CICLOS default.
- One sub-module, temporizador_espera: clear, enable, terminal-count flag at TIMEOUT_CICLOS.
- The FSM and datapath registers stay in secuenciador_mult.

Test Plan:
1. Reset check: hold rst_n low 3 cycles -> all outputs 0, state REPOSO; after release ent_listo=1, num_ops=0.
2. Basic product: 3 x 2 (011, 010) -> mult_start high exactly 1 cycle; sal_valido with sal_resultado=000110, sal_error=0; num_ops=1 after handshake.
3. Signed product: -4 x 3 (100, 011) -> sal_resultado=110100 (-12), sal_error=0.
4. Backpressure: sal_listo low 5 cycles after sal_valido; extra ent_valido pulses meanwhile:
   - sal_resultado is held constant;
   - ent_listo=0 and operands are not relatched;
   - one handshake occurs when sal_listo rises.
5. Timeout: model holds mult_fin=1 permanently -> ESPERA_BAJA never exits; after 16 wait cycles sal_valido=1, sal_error=1, sal_resultado=000000.
6. Mid-operation reset: rst_n pulsed low in ESPERA_FIN -> outputs zero immediately; a following -1 x -1 (111, 111) gives sal_resultado=000001 and num_ops=1.
